aes_round_ctrl: RTL and testbench

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

---
 rtl/aes_pkg.sv | 14 +
 rtl/aes_round_ctrl.sv | 116 +++++++++++
 tb/tb_aes_round_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: widths, round-count default and FSM state type shared by the AES round controller.
package aes_pkg;

    localparam int AES_BLOCK_W    = 128;
    localparam int AES_KEY_W      = 128;
    localparam int AES_NUM_ROUNDS = 10;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } aes_state_t;

endpackage

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: steps an external AES round engine NUM_ROUNDS times per block.
// Optional abort input is present only when AES_ABORT_EN is defined.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES_NUM_ROUNDS,
    parameter int ROUND_LAT  = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
`ifdef AES_ABORT_EN
    input  logic                   abort,
`endif
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] in_data,
    input  logic [AES_KEY_W-1:0]   in_key,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_data,
    output logic                   busy,
    output logic [3:0]             rnd_rc,
    output logic [AES_BLOCK_W-1:0] rnd_data,
    output logic [AES_KEY_W-1:0]   rnd_key,
    output logic                   rnd_last,
    input  logic [AES_BLOCK_W-1:0] rnd_out,
    input  logic [AES_KEY_W-1:0]   rnd_key_out
);

    localparam int LAT_W = (ROUND_LAT > 1) ? $clog2(ROUND_LAT) : 1;

    aes_state_t             r_fsm;
    aes_state_t             w_fsm_next;
    logic [AES_BLOCK_W-1:0] r_state;
    logic [AES_KEY_W-1:0]   r_key;
    logic [3:0]             r_rc;
    logic [LAT_W-1:0]       r_lat_cnt;

    logic w_accept;
    logic w_capture;
    logic w_final;
    logic w_release;
    logic w_abort;

    assign w_accept  = (r_fsm == IDLE) && in_valid;
    assign w_capture = (r_fsm == ROUND) && (r_lat_cnt == LAT_W'(ROUND_LAT - 1));
    assign w_final   = (r_rc == 4'(NUM_ROUNDS));
    assign w_release = (r_fsm == DONE) && out_ready;

`ifdef AES_ABORT_EN
    assign w_abort = abort && (r_fsm != IDLE);
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm <= IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    // Abort overrides every other transition, including a DONE handshake.
    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            IDLE:    if (in_valid) w_fsm_next = ROUND;
            ROUND:   if (w_capture && w_final) w_fsm_next = DONE;
            DONE:    if (out_ready) w_fsm_next = IDLE;
            default: w_fsm_next = IDLE;
        endcase
        if (w_abort) begin
            w_fsm_next = IDLE;
        end
    end

    // Leaving a block (abort or completed handshake) returns every register to its reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= '0;
            r_key     <= '0;
            r_rc      <= 4'd1;
            r_lat_cnt <= '0;
        end else if (w_abort || w_release) begin
            r_state   <= '0;
            r_key     <= '0;
            r_rc      <= 4'd1;
            r_lat_cnt <= '0;
        end else if (w_accept) begin
            r_state   <= in_data ^ in_key;
            r_key     <= in_key;
            r_rc      <= 4'd1;
            r_lat_cnt <= '0;
        end else if (w_capture) begin
            r_state   <= rnd_out;
            r_key     <= rnd_key_out;
            r_lat_cnt <= '0;
            if (!w_final) begin
                r_rc <= r_rc + 4'd1;
            end
        end else if (r_fsm == ROUND) begin
            r_lat_cnt <= r_lat_cnt + LAT_W'(1);
        end
    end

    assign in_ready  = (r_fsm == IDLE);
    assign out_valid = (r_fsm == DONE);
    assign busy      = (r_fsm != IDLE);
    assign out_data  = (r_fsm == DONE)  ? r_state : '0;
    assign rnd_data  = (r_fsm == ROUND) ? r_state : '0;
    assign rnd_key   = (r_fsm == ROUND) ? r_key   : '0;
    assign rnd_rc    = r_rc;
    assign rnd_last  = w_final;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: self-checking bench with a behavioural AES-128 round engine and reference cipher.
// Abort scenarios run only when AES_ABORT_EN is defined.
module tb_aes_round_ctrl;

    localparam int NR = 10;

    typedef struct {
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] ct;
        int           hold;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;

    logic         in_valid, in_ready, out_valid, out_ready, busy, rnd_last;
    logic [127:0] in_data, in_key, out_data, rnd_data, rnd_key, rnd_out, rnd_key_out;
    logic [3:0]   rnd_rc;

    logic         in_valid2, in_ready2, out_valid2, out_ready2, busy2, rnd2_last;
    logic [127:0] in_data2, in_key2, out_data2, rnd2_data, rnd2_key, rnd2_out, rnd2_key_out;
    logic [3:0]   rnd2_rc;

`ifdef AES_ABORT_EN
    logic abort;
`endif

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[3];

    always #5 clk = ~clk;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from first principles: multiplicative inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] subBytes(input logic [127:0] d);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(d[8*i +: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shiftRows(input logic [127:0] d);
        logic [127:0] o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-8*(r+4*c) -: 8] = d[127-8*(r+4*((c+r)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mixColumns(input logic [127:0] d);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = d[127-32*c -: 8];
            a1 = d[119-32*c -: 8];
            a2 = d[111-32*c -: 8];
            a3 = d[103-32*c -: 8];
            o[127-32*c -: 32] = {gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3,
                                 a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3,
                                 a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03),
                                 gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02)};
        end
        return o;
    endfunction

    function automatic logic [127:0] nextKey(input logic [127:0] k, input logic [3:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        logic [7:0]  rcon;
        {w0, w1, w2, w3} = k;
        rcon = 8'h01;
        for (int i = 1; i < int'(rc); i++) rcon = xtime(rcon);
        t  = {w3[23:0], w3[31:24]};
        t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rcon, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [255:0] roundEngine(input logic [127:0] d, input logic [127:0] k,
                                                 input logic [3:0] rc, input logic last);
        logic [127:0] nk;
        logic [127:0] s;
        nk = nextKey(k, rc);
        s  = shiftRows(subBytes(d));
        if (!last) s = mixColumns(s);
        return {s ^ nk, nk};
    endfunction

    function automatic logic [127:0] aesRef(input logic [127:0] pt, input logic [127:0] key);
        logic [127:0] s;
        logic [127:0] k;
        s = pt ^ key;
        k = key;
        for (int r = 1; r <= NR; r++) begin
            k = nextKey(k, 4'(r));
            s = shiftRows(subBytes(s));
            if (r != NR) s = mixColumns(s);
            s = s ^ k;
        end
        return s;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    aes_round_ctrl #(.NUM_ROUNDS(NR), .ROUND_LAT(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef AES_ABORT_EN
        .abort       (abort),
`endif
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_key      (in_key),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .busy        (busy),
        .rnd_rc      (rnd_rc),
        .rnd_data    (rnd_data),
        .rnd_key     (rnd_key),
        .rnd_last    (rnd_last),
        .rnd_out     (rnd_out),
        .rnd_key_out (rnd_key_out)
    );

    assign {rnd_out, rnd_key_out} = roundEngine(rnd_data, rnd_key, rnd_rc, rnd_last);

    aes_round_ctrl #(.NUM_ROUNDS(NR), .ROUND_LAT(2)) dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef AES_ABORT_EN
        .abort       (1'b0),
`endif
        .in_valid    (in_valid2),
        .in_ready    (in_ready2),
        .in_data     (in_data2),
        .in_key      (in_key2),
        .out_valid   (out_valid2),
        .out_ready   (out_ready2),
        .out_data    (out_data2),
        .busy        (busy2),
        .rnd_rc      (rnd2_rc),
        .rnd_data    (rnd2_data),
        .rnd_key     (rnd2_key),
        .rnd_last    (rnd2_last),
        .rnd_out     (rnd2_out),
        .rnd_key_out (rnd2_key_out)
    );

    // Two-cycle engine: its result is stale on the first cycle after new inputs are driven.
    always @(posedge clk) begin
        {rnd2_out, rnd2_key_out} <= roundEngine(rnd2_data, rnd2_key, rnd2_rc, rnd2_last);
    end

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // One block through dut: accept, per-cycle round checks with noisy inputs, DONE hold, release.
    task automatic applyStimulus(input logic [127:0] pt, input logic [127:0] key,
                                 input logic [127:0] expCt, input int holdCycles);
        int n;
        @(negedge clk);
        checkOutput("ready_before_accept", 256'(in_ready), 256'(1'b1));
        in_valid  = 1'b1;
        in_data   = pt;
        in_key    = key;
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput("first_round_bus", {rnd_data, rnd_key}, {pt ^ key, key});
        n = 0;
        while (!out_valid && n < 100) begin
            if (n < NR)
                checkOutput("round_status", 256'({busy, in_ready, out_valid, rnd_last, rnd_rc}),
                            256'({1'b1, 1'b0, 1'b0, (n == NR - 1), 4'(n + 1)}));
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = rand128();
            in_key    = rand128();
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        checkOutput("latency", 256'(n), 256'(NR));
        checkOutput("done_data", 256'(out_data), 256'(expCt));
        for (int h = 0; h < holdCycles; h++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = rand128();
            @(negedge clk);
            checkOutput("done_hold", 256'({busy, in_ready, out_valid, out_data}),
                        256'({1'b1, 1'b0, 1'b1, expCt}));
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = rand128();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checkOutput("released_idle", 256'({busy, in_ready, out_valid, out_data}),
                    256'({1'b0, 1'b1, 1'b0, 128'h0}));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [127:0] pt;
        logic [127:0] key;
        int           n;
        logic         seen;

        vecs[0] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, 5};
        vecs[1] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3925841d02dc09fbdc118597196a0b32, 0};
        vecs[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 2};

        rst_n      = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        in_key     = '0;
        out_ready  = 1'b0;
        in_valid2  = 1'b0;
        in_data2   = '0;
        in_key2    = '0;
        out_ready2 = 1'b0;
`ifdef AES_ABORT_EN
        abort      = 1'b0;
`endif
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_ctrl", 256'({busy, out_valid, rnd_last, rnd_rc}), 256'({1'b0, 1'b0, 1'b0, 4'd1}));
        checkOutput("reset_round_bus", {rnd_data, rnd_key}, 256'h0);
        checkOutput("reset_out_data", 256'(out_data), 256'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_reset", 256'({in_ready, busy, out_valid}), 256'(3'b100));

        for (int i = 0; i < 3; i++) begin
            $display("[TB] known-answer vector %0d", i);
            applyStimulus(vecs[i].pt, vecs[i].key, vecs[i].ct, vecs[i].hold);
        end

        for (int i = 0; i < 5; i++) begin
            pt  = rand128();
            key = rand128();
            applyStimulus(pt, key, aesRef(pt, key), int'($urandom_range(0, 3)));
        end

        $display("[TB] reset during the fourth ROUND cycle");
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = rand128();
        in_key   = rand128();
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_reset_ctrl", 256'({busy, out_valid, rnd_last, rnd_rc}), 256'({1'b0, 1'b0, 1'b0, 4'd1}));
        checkOutput("mid_reset_round_bus", {rnd_data, rnd_key}, 256'h0);
        checkOutput("mid_reset_out_data", 256'(out_data), 256'h0);
        @(negedge clk);
        rst_n = 1'b1;
        pt  = rand128();
        key = rand128();
        applyStimulus(pt, key, aesRef(pt, key), 1);

        $display("[TB] ROUND_LAT=2 instance");
        pt  = vecs[0].pt;
        key = vecs[0].key;
        @(negedge clk);
        in_valid2 = 1'b1;
        in_data2  = pt;
        in_key2   = key;
        @(negedge clk);
        in_valid2 = 1'b0;
        n = 0;
        while (!out_valid2 && n < 200) begin
            if (n < 2 * NR)
                checkOutput("lat2_rc", 256'({busy2, rnd2_rc}), 256'({1'b1, 4'(n / 2 + 1)}));
            @(negedge clk);
            n++;
        end
        checkOutput("lat2_latency", 256'(n), 256'(2 * NR));
        checkOutput("lat2_data", 256'(out_data2), 256'(vecs[0].ct));
        out_ready2 = 1'b1;
        @(negedge clk);
        out_ready2 = 1'b0;
        checkOutput("lat2_release", 256'({in_ready2, out_valid2}), 256'(2'b10));

`ifdef AES_ABORT_EN
        $display("[TB] abort at round 6");
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = rand128();
        in_key   = rand128();
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("abort_at_round6", 256'(rnd_rc), 256'(4'd6));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_idle", 256'({busy, in_ready, out_valid, rnd_rc}), 256'({1'b0, 1'b1, 1'b0, 4'd1}));
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checkOutput("abort_no_valid", 256'(seen), 256'h0);

        $display("[TB] abort together with out_ready in DONE");
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = rand128();
        in_key   = rand128();
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("abort_done_reached", 256'(n), 256'(NR));
        abort     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        abort     = 1'b0;
        out_ready = 1'b0;
        checkOutput("abort_done_idle", 256'({busy, in_ready, out_valid, out_data}), 256'({1'b0, 1'b1, 1'b0, 128'h0}));
        pt  = rand128();
        key = rand128();
        applyStimulus(pt, key, aesRef(pt, key), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
